// File: rtl/riscv_dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: MemOp encodings, FSM states
// and the MemOp legality rule used by the request checker.
package riscv_dmem_responder_pkg;

    localparam logic [2:0] MEMOP_LB  = 3'b000;
    localparam logic [2:0] MEMOP_LH  = 3'b001;
    localparam logic [2:0] MEMOP_LW  = 3'b010;
    localparam logic [2:0] MEMOP_LBU = 3'b100;
    localparam logic [2:0] MEMOP_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Unsigned variants only make sense for loads.
    function automatic logic memop_legal(input logic [2:0] memop, input logic we);
        logic ok;
        case (memop)
            MEMOP_LB, MEMOP_LH, MEMOP_LW: ok = 1'b1;
            MEMOP_LBU, MEMOP_LHU:         ok = !we;
            default:                      ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/riscv_mem_lane.sv
// Byte-lane datapath: store merge into the old word, load extraction with
// sign/zero extension, and natural-alignment check for the access size.
module riscv_mem_lane
    import riscv_dmem_responder_pkg::*;
(
    input  logic [2:0]  memop,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_word,
    output logic [31:0] st_word,
    output logic [31:0] ld_value,
    output logic        misalign
);

    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    // memop[1:0] encodes the access size for both signed and unsigned forms.
    always_comb begin
        misalign = 1'b0;
        st_word  = old_word;
        case (memop[1:0])
            2'b00: st_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            2'b01: begin
                misalign = addr_lo[0];
                st_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            end
            2'b10: begin
                misalign = (addr_lo != 2'b00);
                st_word  = wdata;
            end
            default: ;
        endcase
    end

    assign byte_sel = rdata_word[{addr_lo, 3'b000} +: 8];
    assign half_sel = rdata_word[{addr_lo[1], 4'b0000} +: 16];
    assign byte_s   = signed'(byte_sel);
    assign half_s   = signed'(half_sel);

    always_comb begin
        ld_value = rdata_word;
        case (memop)
            MEMOP_LB:  ld_value = 32'(byte_s);
            MEMOP_LH:  ld_value = 32'(half_s);
            MEMOP_LBU: ld_value = {24'b0, byte_sel};
            MEMOP_LHU: ld_value = {16'b0, half_sel};
            default:   ld_value = rdata_word;
        endcase
    end

endmodule

// File: rtl/riscv_dmem_responder.sv
// Handshaked data-memory responder: one outstanding request, programmable
// wait states, byte-lane stores and extended loads, one-cycle response pulse.
module riscv_dmem_responder
    import riscv_dmem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [2:0]  req_memop_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int          AW          = $clog2(DEPTH_WORDS);
    localparam logic [32:0] RANGE_BYTES = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  CNT_LOAD    = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_e      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic        go_resp;
    logic        accept;

    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  memop_q;

    logic        cur_we;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [2:0]  cur_memop;

    logic [31:0]   off;
    logic [AW-1:0] word_idx;
    logic          out_of_range;
    logic          misalign;
    logic          illegal;
    logic          err;
    logic [31:0]   old_word;
    logic [31:0]   st_word;
    logic [31:0]   ld_value;

    logic [31:0] mem [DEPTH_WORDS];

    assign req_ready_o = (state == ST_IDLE) && !rst;
    assign accept      = req_valid_i && req_ready_o;
    assign rsp_valid_o = (state == ST_RESP);

    // With zero wait states the access commits on the accept edge itself, so
    // the live request is used while idle and the latched copy otherwise.
    assign cur_we    = (state == ST_IDLE) ? req_we_i    : we_q;
    assign cur_addr  = (state == ST_IDLE) ? req_addr_i  : addr_q;
    assign cur_wdata = (state == ST_IDLE) ? req_wdata_i : wdata_q;
    assign cur_memop = (state == ST_IDLE) ? req_memop_i : memop_q;

    assign off          = cur_addr - BASE_ADDR;
    assign out_of_range = ({1'b0, off} >= RANGE_BYTES);
    assign word_idx     = off[AW+1:2];
    assign old_word     = mem[word_idx];
    assign illegal      = !memop_legal(cur_memop, cur_we);
    assign err          = out_of_range || misalign || illegal;

    riscv_mem_lane u_lane (
        .memop      (cur_memop),
        .addr_lo    (cur_addr[1:0]),
        .old_word   (old_word),
        .wdata      (cur_wdata),
        .rdata_word (old_word),
        .st_word    (st_word),
        .ld_value   (ld_value),
        .misalign   (misalign)
    );

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        go_resp    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES > 0) begin
                        state_next = ST_WAIT;
                        cnt_next   = CNT_LOAD;
                    end else begin
                        state_next = ST_RESP;
                        go_resp    = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    state_next = ST_RESP;
                    go_resp    = 1'b1;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= 4'd0;
            rsp_rdata_o <= 32'd0;
            rsp_err_o   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (go_resp) begin
                rsp_err_o   <= err;
                rsp_rdata_o <= (cur_we || err) ? 32'd0 : ld_value;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            memop_q <= req_memop_i;
        end
    end

    always_ff @(posedge clk) begin
        if (go_resp && !rst && cur_we && !err) begin
            mem[word_idx] <= st_word;
        end
    end

endmodule
